// File: rtl/riscv_crypto_saes32_round_seq.sv
// -----------------------------------------------------------------------------
// riscv_crypto_saes32_round_seq
//
// Sequences one full AES round (encrypt or decrypt, middle or final) as sixteen
// byte-wise operations on an external saes32 functional unit. The round input
// state and round key are captured on request. For each column, the round key
// word is passed through four FU operations, one per row. Each operation folds in
// one ShiftRows-selected state byte. The fourth result of a column is that column
// of the round output.
//
// Build option:
//   RISCV_CRYPTO_SAES32_ROUND_DEC_EN  defined   -> decrypt rounds supported
//                                     undefined -> req_dec ignored (encrypt only)
//
// Ports:
//   g_clk, g_rst            clock, synchronous active-high reset
//   req_valid/req_ready     round request handshake
//   req_dec, req_last       decrypt round / final round (no (Inv)MixColumns)
//   req_state, req_rkey     128-bit round input state and round key
//                           (word i = bits [32i+31:32i] = column i)
//   rsp_valid/rsp_ready     result handshake
//   rsp_state               128-bit round output, same layout as req_state
//   fu_valid/fu_ready       issue handshake to the saes32 functional unit
//   fu_rs1, fu_rs2, fu_bs   FU operands and byte select
//   fu_op_*                 one-hot FU operation select (ssm4 ops tied 0)
//   fu_rd                   FU result, used only on the issue handshake
// -----------------------------------------------------------------------------
module riscv_crypto_saes32_round_seq (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_dec,
    input  logic         req_last,
    input  logic [127:0] req_state,
    input  logic [127:0] req_rkey,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_state,
    output logic         fu_valid,
    input  logic         fu_ready,
    output logic [31:0]  fu_rs1,
    output logic [31:0]  fu_rs2,
    output logic [1:0]   fu_bs,
    output logic         fu_op_encs,
    output logic         fu_op_encsm,
    output logic         fu_op_decs,
    output logic         fu_op_decsm,
    output logic         fu_op_ssm4_ks,
    output logic         fu_op_ssm4_ed,
    input  logic [31:0]  fu_rd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       state_r;
    logic [3:0]   cnt_r;
    logic [31:0]  acc_r;
    logic [127:0] st_r;
    logic [127:0] rk_r;
    logic         dec_r;
    logic         last_r;
    logic [127:0] res_r;

    logic         req_dec_s;
    logic [1:0]   col_s;
    logic [1:0]   bs_s;
    logic [1:0]   idx_s;

    // Selects 32-bit word i (column i) of a 128-bit block.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = v[31:0];
            2'd1:    w = v[63:32];
            2'd2:    w = v[95:64];
            2'd3:    w = v[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign col_s = cnt_r[3:2];
    assign bs_s  = cnt_r[1:0];

`ifdef RISCV_CRYPTO_SAES32_ROUND_DEC_EN
    assign req_dec_s = req_dec;

    // ShiftRows takes row bs from column col+bs; InvShiftRows takes it from col-bs.
    always_comb begin
        idx_s = 2'd0;
        if (dec_r) begin
            idx_s = col_s - bs_s;
        end else begin
            idx_s = col_s + bs_s;
        end
    end

    assign fu_op_encsm = fu_valid & ~dec_r & ~last_r;
    assign fu_op_encs  = fu_valid & ~dec_r &  last_r;
    assign fu_op_decsm = fu_valid &  dec_r & ~last_r;
    assign fu_op_decs  = fu_valid &  dec_r &  last_r;
`else
    // Encrypt-only build: the decrypt request bit is forced to zero here.
    assign req_dec_s = req_dec & 1'b0;
    assign idx_s     = col_s + bs_s;

    assign fu_op_encsm = fu_valid & ~dec_r & ~last_r;
    assign fu_op_encs  = fu_valid & ~dec_r &  last_r;
    assign fu_op_decsm = 1'b0;
    assign fu_op_decs  = 1'b0;
`endif

    assign fu_op_ssm4_ks = 1'b0;
    assign fu_op_ssm4_ed = 1'b0;

    assign req_ready = (state_r == S_IDLE);
    assign fu_valid  = (state_r == S_ISSUE);
    assign rsp_valid = (state_r == S_DONE);
    assign rsp_state = res_r;

    // Operands are decoded from registers only, so they hold still across a
    // stall, and they read zero outside ISSUE.
    always_comb begin
        fu_rs1 = 32'd0;
        fu_rs2 = 32'd0;
        fu_bs  = 2'd0;
        if (fu_valid) begin
            fu_bs  = bs_s;
            fu_rs2 = word_sel(st_r, idx_s);
            if (bs_s == 2'd0) begin
                fu_rs1 = word_sel(rk_r, col_s);
            end else begin
                fu_rs1 = acc_r;
            end
        end else begin
            fu_rs1 = 32'd0;
            fu_rs2 = 32'd0;
            fu_bs  = 2'd0;
        end
    end

    // Round sequencer: capture, sixteen FU handshakes, then hold the result.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            acc_r   <= 32'd0;
            res_r   <= 128'd0;
            st_r    <= 128'd0;
            rk_r    <= 128'd0;
            dec_r   <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        st_r    <= req_state;
                        rk_r    <= req_rkey;
                        dec_r   <= req_dec_s;
                        last_r  <= req_last;
                        cnt_r   <= 4'd0;
                        state_r <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (fu_ready) begin
                        acc_r <= fu_rd;
                        cnt_r <= cnt_r + 4'd1;
                        // The row-3 result completes the column.
                        if (bs_s == 2'd3) begin
                            res_r[{col_s, 5'd0} +: 32] <= fu_rd;
                        end
                        if (cnt_r == 4'd15) begin
                            state_r <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_crypto_saes32_round_seq.sv
// -----------------------------------------------------------------------------
// tb_riscv_crypto_saes32_round_seq
//
// Bench for riscv_crypto_saes32_round_seq. The bench plays the saes32
// functional unit itself. It holds an instruction-level FU model, a
// byte-matrix AES round model, and the expected FU operand sequence. One compare
// process checks every DUT output on each falling edge against the phase the
// stimulus expects. The FIPS-197 vectors pin the round model to known answers.
// -----------------------------------------------------------------------------
module tb_riscv_crypto_saes32_round_seq;

    logic         g_clk = 1'b0;
    logic         g_rst;
    logic         req_valid, req_ready, req_dec, req_last;
    logic [127:0] req_state, req_rkey;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_state;
    logic         fu_valid, fu_ready;
    logic [31:0]  fu_rs1, fu_rs2, fu_rd;
    logic [1:0]   fu_bs;
    logic         fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm;
    logic         fu_op_ssm4_ks, fu_op_ssm4_ed;

    always #5 g_clk = ~g_clk;

    riscv_crypto_saes32_round_seq dut (
        .g_clk(g_clk), .g_rst(g_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dec(req_dec), .req_last(req_last),
        .req_state(req_state), .req_rkey(req_rkey),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_bs(fu_bs),
        .fu_op_encs(fu_op_encs), .fu_op_encsm(fu_op_encsm),
        .fu_op_decs(fu_op_decs), .fu_op_decsm(fu_op_decsm),
        .fu_op_ssm4_ks(fu_op_ssm4_ks), .fu_op_ssm4_ed(fu_op_ssm4_ed),
        .fu_rd(fu_rd)
    );

    localparam int P_SKIP = 0, P_IDLE = 1, P_ISSUE = 2, P_DONE = 3;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    int           n_vec = 0;
    int           n_miss = 0;
    int           exp_phase = P_SKIP;
    int           exp_k = 0;
    logic         after_rst = 1'b0;
    logic [31:0]  seq_rs1 [16];
    logic [31:0]  seq_rs2 [16];
    logic [127:0] m_res;
    logic         m_dec, m_last;
    logic         lit_en = 1'b0;
    logic [127:0] lit_res;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Byte list "b0 b1 ... b15" written as one hex literal -> byte k at [8k+7:8k].
    function automatic logic [127:0] brev(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    // Instruction-level saes32 behaviour (es/esmi/ds/dsmi).
    function automatic logic [31:0] fu_model(input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [1:0] bs, input logic dec, input logic mix);
        logic [31:0] sh, u;
        logic [7:0]  x, s;
        int          amt;
        amt = 8 * int'(bs);
        sh  = rs2 >> amt;
        x   = sh[7:0];
        if (!dec) begin
            s = sb[x];
            u = mix ? {gmul(s, 8'h03), s, s, gmul(s, 8'h02)} : {24'd0, s};
        end else begin
            s = isb[x];
            u = mix ? {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)} : {24'd0, s};
        end
        return rs1 ^ ((u << amt) | (u >> (32 - amt)));
    endfunction

    // Round-level AES model on a 4x4 byte matrix, byte 4c+r = row r of column c.
    function automatic logic [127:0] round_model(input logic [127:0] st, input logic [127:0] rk,
                                                 input logic dec, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   m0, m1, m2, m3;
        logic [127:0] r;
        int           src;
        for (int i = 0; i < 16; i++) a[i] = st[8*i +: 8];
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                src = dec ? (c - rw + 4) % 4 : (c + rw) % 4;
                t[4*c+rw] = dec ? isb[a[4*src+rw]] : sb[a[4*src+rw]];
            end
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                m0 = t[4*c]; m1 = t[4*c+1]; m2 = t[4*c+2]; m3 = t[4*c+3];
                if (!dec) begin
                    t[4*c]   = gmul(m0, 8'h02) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
                    t[4*c+1] = m0 ^ gmul(m1, 8'h02) ^ gmul(m2, 8'h03) ^ m3;
                    t[4*c+2] = m0 ^ m1 ^ gmul(m2, 8'h02) ^ gmul(m3, 8'h03);
                    t[4*c+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ gmul(m3, 8'h02);
                end else begin
                    t[4*c]   = gmul(m0, 8'h0e) ^ gmul(m1, 8'h0b) ^ gmul(m2, 8'h0d) ^ gmul(m3, 8'h09);
                    t[4*c+1] = gmul(m0, 8'h09) ^ gmul(m1, 8'h0e) ^ gmul(m2, 8'h0b) ^ gmul(m3, 8'h0d);
                    t[4*c+2] = gmul(m0, 8'h0d) ^ gmul(m1, 8'h09) ^ gmul(m2, 8'h0e) ^ gmul(m3, 8'h0b);
                    t[4*c+3] = gmul(m0, 8'h0b) ^ gmul(m1, 8'h0d) ^ gmul(m2, 8'h09) ^ gmul(m3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = t[i] ^ rk[8*i +: 8];
        return r;
    endfunction

    // The bench acts as the functional unit.
    assign fu_rd = fu_model(fu_rs1, fu_rs2, fu_bs, fu_op_decs | fu_op_decsm, fu_op_encsm | fu_op_decsm);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Single compare process: every output, every cycle, against the expected phase.
    always @(negedge g_clk) begin
        case (exp_phase)
            P_IDLE: begin
                chk("req_ready_idle", req_ready, 128'd1);
                chk("fu_valid_idle", fu_valid, 128'd0);
                chk("rsp_valid_idle", rsp_valid, 128'd0);
                if (after_rst) begin
                    chk("fu_rs1_rst", fu_rs1, 128'd0);
                    chk("fu_rs2_rst", fu_rs2, 128'd0);
                    chk("fu_bs_rst", fu_bs, 128'd0);
                    chk("fu_ops_rst", {fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm,
                                       fu_op_ssm4_ks, fu_op_ssm4_ed}, 128'd0);
                end
            end
            P_ISSUE: begin
                chk("req_ready_issue", req_ready, 128'd0);
                chk("fu_valid_issue", fu_valid, 128'd1);
                chk("rsp_valid_issue", rsp_valid, 128'd0);
                chk("fu_bs", fu_bs, 128'(exp_k % 4));
                chk("fu_rs1", fu_rs1, seq_rs1[exp_k]);
                chk("fu_rs2", fu_rs2, seq_rs2[exp_k]);
                chk("fu_ops", {fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm, fu_op_ssm4_ks, fu_op_ssm4_ed},
                    {~m_dec & m_last, ~m_dec & ~m_last, m_dec & m_last, m_dec & ~m_last, 2'b00});
            end
            P_DONE: begin
                chk("req_ready_done", req_ready, 128'd0);
                chk("fu_valid_done", fu_valid, 128'd0);
                chk("rsp_valid_done", rsp_valid, 128'd1);
                chk("rsp_state_model", rsp_state, m_res);
                if (lit_en) chk("rsp_state_literal", rsp_state, lit_res);
            end
            default: ;
        endcase
    end

    // One round transaction. stall_at/stall_len: fu_ready low at that op count.
    // bp_len: cycles of rsp_ready low. rst_at: pulse g_rst at that op count (-1 none).
    task automatic do_round(input logic [127:0] st, input logic [127:0] rk, input logic dec,
                            input logic last, input int stall_at, input int stall_len,
                            input int bp_len, input int rst_at);
        logic [31:0] acc;
        logic        eff_dec;
        int          col, bs, idx, k, stall_left;
`ifdef RISCV_CRYPTO_SAES32_ROUND_DEC_EN
        eff_dec = dec;
`else
        eff_dec = 1'b0;
`endif
        m_dec  = eff_dec;
        m_last = last;
        m_res  = round_model(st, rk, eff_dec, last);
        acc    = 32'd0;
        for (int j = 0; j < 16; j++) begin
            col = j / 4;
            bs  = j % 4;
            idx = eff_dec ? (col - bs + 4) % 4 : (col + bs) % 4;
            seq_rs2[j] = st[32*idx +: 32];
            seq_rs1[j] = (bs == 0) ? rk[32*col +: 32] : acc;
            acc = fu_model(seq_rs1[j], seq_rs2[j], 2'(bs), eff_dec, ~last);
        end
        // Cycle 0: request offered while IDLE.
        req_valid = 1'b1; req_state = st; req_rkey = rk; req_dec = dec; req_last = last;
        fu_ready = 1'b1; rsp_ready = 1'b0;
        @(posedge g_clk); #1;
        after_rst  = 1'b0;
        exp_phase  = P_ISSUE;
        k          = 0;
        stall_left = stall_len;
        while (k < 16) begin
            exp_k = k;
            // Request inputs churn after acceptance; the DUT must ignore them.
            req_valid = 1'($urandom);
            req_state = {$urandom, $urandom, $urandom, $urandom};
            req_rkey  = {$urandom, $urandom, $urandom, $urandom};
            req_dec   = 1'($urandom);
            req_last  = 1'($urandom);
            if (k == stall_at && stall_left > 0) begin
                fu_ready = 1'b0;
                stall_left--;
            end else begin
                fu_ready = 1'b1;
            end
            if (k == rst_at) g_rst = 1'b1;
            @(posedge g_clk); #1;
            if (g_rst) begin
                g_rst = 1'b0; req_valid = 1'b0; fu_ready = 1'b1;
                exp_phase = P_IDLE; after_rst = 1'b1;
                repeat (3) @(posedge g_clk);
                #1;
                return;
            end
            if (fu_ready) k++;
        end
        exp_phase = P_DONE;
        for (int b = 0; b < bp_len; b++) begin
            rsp_ready = 1'b0;
            req_valid = 1'($urandom);
            @(posedge g_clk); #1;
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge g_clk); #1;
        rsp_ready = 1'b0;
        exp_phase = P_IDLE;
    endtask

    logic [127:0] st29, rk29, res29, st30, rk30, res30;

    initial begin
        logic [7:0] inv, b;
        g_rst = 1'b1; req_valid = 1'b0; req_dec = 1'b0; req_last = 1'b0;
        req_state = 128'd0; req_rkey = 128'd0; rsp_ready = 1'b0; fu_ready = 1'b0;
        // S-box from its definition: GF(2^8) inverse followed by the affine map.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

        st29  = brev(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        rk29  = brev(128'ha0fafe1788542cb123a339392a6c7605);
        res29 = brev(128'ha49c7ff2689f352b6b5bea43026a5049);
        st30  = brev(128'heb40f21e592e38848ba113e71bc342d2);
        rk30  = brev(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        res30 = brev(128'h3925841d02dc09fbdc118597196a0b32);

        repeat (3) @(posedge g_clk);
        #1;
        g_rst = 1'b0;
        exp_phase = P_IDLE;
        after_rst = 1'b1;
        @(posedge g_clk); #1;

        // FIPS-197 middle round, no stalls.
        lit_en = 1'b1; lit_res = res29;
        do_round(st29, rk29, 1'b0, 1'b0, -1, 0, 0, -1);
        // FIPS-197 last round.
        lit_res = res30;
        do_round(st30, rk30, 1'b0, 1'b1, -1, 0, 0, -1);
`ifdef RISCV_CRYPTO_SAES32_ROUND_DEC_EN
        // Decrypt last round undoes the encrypt last round.
        lit_res = st30;
        do_round(res30 ^ rk30, 128'd0, 1'b1, 1'b1, -1, 0, 0, -1);
`else
        // Decrypt request is treated as encrypt in this build.
        lit_res = res30;
        do_round(st30, rk30, 1'b1, 1'b1, -1, 0, 0, -1);
`endif
        // FU stall of three cycles at op 5, then response back-pressure.
        lit_res = res29;
        do_round(st29, rk29, 1'b0, 1'b0, 5, 3, 0, -1);
        do_round(st29, rk29, 1'b0, 1'b0, -1, 0, 4, -1);
        lit_en = 1'b0;
        // Reset in the middle of the op sequence abandons the round.
        do_round(st29, rk29, 1'b0, 1'b0, -1, 0, 0, 9);
        do_round(st30, rk30, 1'b0, 1'b1, -1, 0, 0, 15);

        for (int n = 0; n < 24; n++) begin
            do_round({$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), (n % 8 == 7) ? int'($urandom_range(0, 15)) : -1);
        end

        @(posedge g_clk); #1;
        exp_phase = P_SKIP;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_crypto_saes32_round_seq.md
RISCV_CRYPTO_SAES32_ROUND_SEQ -- requirements
Module: riscv_crypto_saes32_round_seq

Interface
REQ-001 Parameters: none; the only build option is the macro in REQ-024.
REQ-002 g_clk  in  1  single clock; all state updates on rising edge.
REQ-003 g_rst  in  1  synchronous, active-high reset.
REQ-004 req_valid / req_ready  in / out  1 / 1  round request handshake.
REQ-005 req_dec  in  1  1 = decrypt round, 0 = encrypt round.
REQ-006 req_last  in  1  1 = final round, no (Inv)MixColumns.
REQ-007 req_state / req_rkey  in  128 each  round input state and round key; word i = bits [32i+31:32i] = column i; byte k = bits [8k+7:8k].
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  result handshake; rsp_state  out  128  round output, same layout as req_state.
REQ-009 fu_valid / fu_ready  out / in  1 / 1  issue handshake to the saes32 functional unit; fu_ready may be combinational on fu_valid.
REQ-010 fu_rs1 / fu_rs2  out  32 each; fu_bs  out  2; fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm  out  1 each; fu_op_ssm4_ks and fu_op_ssm4_ed  out  1 each, tied 0.
REQ-011 fu_rd  in  32  functional unit result, sampled only when fu_valid and fu_ready are both high.

Function
REQ-012 States: IDLE, ISSUE, DONE; req_ready = (state == IDLE); fu_valid = (state == ISSUE); rsp_valid = (state == DONE).
REQ-013 IDLE: on req_valid, capture req_state, req_rkey, req_dec, req_last; clear the 4-bit op counter; go to ISSUE.
REQ-014 The op counter holds col = cnt[3:2] and bs = cnt[1:0]; fu_bs = bs.
REQ-015 fu_rs2 = captured state word ((col + bs) mod 4) for encrypt and ((col - bs) mod 4) for decrypt.
REQ-016 fu_rs1 = captured rkey word col when bs == 0; otherwise it is the 32-bit accumulator.
REQ-017 Op select is exactly one-hot: encsm (enc, not last), encs (enc, last), decsm (dec, not last), decs (dec, last).
REQ-018 On each FU handshake: accumulator <= fu_rd and cnt increments; if bs == 3, result word col <= fu_rd.
REQ-019 The handshake with cnt == 15 moves ISSUE to DONE; the 16 handshakes occur in strict cnt order 0..15.
REQ-020 While fu_ready is low, all fu_* outputs hold stable and no state changes; there is no timeout.
REQ-021 Latency with fu_ready always high: request accepted in cycle 0, ISSUE in cycles 1-16, rsp_valid first high in cycle 17; each fu_ready-low cycle adds one cycle.
REQ-022 DONE: rsp_state is held stable until rsp_ready; on rsp_valid and rsp_ready, go to IDLE. A new request is accepted no earlier than the following cycle.
REQ-023 req_valid is ignored outside IDLE; captured inputs are immune to req_* changes after acceptance.

Configuration
REQ-024 Macro RISCV_CRYPTO_SAES32_ROUND_DEC_EN defined: decrypt fully supported per REQ-015 and REQ-017.
REQ-025 Macro undefined: req_dec is ignored and treated as 0; fu_op_decs and fu_op_decsm are constant 0; the decrypt index logic is removed.

Reset
REQ-026 While g_rst is high at a clock edge: state <= IDLE, cnt <= 0, accumulator <= 0, rsp_state <= 0.
REQ-027 Outputs after reset: req_ready = 1; fu_valid = 0; rsp_valid = 0; all fu_op_* = 0; fu_rs1, fu_rs2 and fu_bs = 0.
REQ-028 Reset during ISSUE or DONE abandons the operation with no rsp_valid, and takes priority over any simultaneous handshake.

Verification
REQ-029 Encrypt middle round with the FIPS-197 App. B round-1 vectors, byte k at bits [8k+7:8k]:
- state = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08
- rkey = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05
- required: rsp_state = a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49, with rsp_valid in cycle 17.
REQ-030 Encrypt last round:
- state = eb 40 f2 1e 59 2e 38 84 8b a1 13 e7 1b c3 42 d2
- rkey = d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6
- required: rsp_state = 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32; only fu_op_encs is asserted.
REQ-031 Decrypt last round (macro defined): state = REQ-030 result XOR REQ-030 rkey, rkey = 0 -> required: rsp_state = REQ-030 input state; only fu_op_decs is asserted.
REQ-032 FU stall: fu_ready low for 3 cycles at cnt == 5, same vectors as REQ-029 -> fu_* stable during the stall; same result; rsp_valid in cycle 20.
REQ-033 Back-pressure and reset:
- rsp_ready low for 4 cycles -> rsp_state stable and req_ready = 0 throughout.
- g_rst pulsed at cnt == 9 -> next cycle IDLE, req_ready = 1, no rsp_valid.
